// File: rtl/clock_divisor_multi_if.sv
// Control/status bundle for clock_divisor_multi: global enable/clear, ratio-load handshake
// and per-channel tick / divided-clock / tap outputs.
interface clock_divisor_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 24,
    parameter int TAP_W  = 22
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              en;
    logic              sync_clr;
    logic              ld_valid;
    logic [CH_W-1:0]   ld_ch;
    logic [DIV_W-1:0]  ld_div;
    logic              ld_ready;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;
    logic [TAP_W-1:0]  tap;

    modport master (
        output en, sync_clr, ld_valid, ld_ch, ld_div,
        input  ld_ready, tick, clk_out, tap
    );

    modport slave (
        input  en, sync_clr, ld_valid, ld_ch, ld_div,
        output ld_ready, tick, clk_out, tap
    );
endinterface

// File: rtl/clock_divisor_multi.sv
// Multi-channel clock divider with runtime divide ratios applied at each channel's wrap.
// Optional legacy free-running tap counter enabled by defining CLKDIV_TAP_EN.
module clock_divisor_multi #(
    parameter int          NUM_CH      = 4,
    parameter int          DIV_W       = 24,
    parameter int unsigned DEFAULT_DIV = 4,
    parameter int          TAP_W       = 22
) (
    input  logic                  clk,
    input  logic                  rst_n,
    clock_divisor_multi_if.slave  bus
);
    localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    // Ratios 0 and 1 both mean divide-by-1.
    function automatic logic [DIV_W-1:0] eff_of(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(1) : d;
    endfunction

    logic [NUM_CH-1:0] pend_vec;
    logic [NUM_CH-1:0] tick_vec;
    logic [NUM_CH-1:0] clk_out_vec;
    logic              ld_ready;

    // Out-of-range channel numbers match no channel, so ld_ready stays low for them.
    always_comb begin
        ld_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ld_ch == CH_W'(i)) begin
                ld_ready = ~pend_vec[i];
            end
        end
    end

    assign bus.ld_ready = ld_ready;
    assign bus.tick     = tick_vec;
    assign bus.clk_out  = clk_out_vec;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] pend_div_q, pend_div_d;
        logic [DIV_W-1:0] div_eff;
        logic             pend_q, pend_d;
        logic             clk_out_q, clk_out_d;
        logic             wrap;
        logic             ld_acc;

        assign div_eff = eff_of(div_q);
        assign wrap    = (cnt_q == div_eff - DIV_W'(1));
        assign ld_acc  = bus.ld_valid & (bus.ld_ch == CH_W'(gi)) & ~pend_q;

        always_comb begin
            cnt_d      = cnt_q;
            div_d      = div_q;
            pend_d     = pend_q;
            pend_div_d = pend_div_q;
            clk_out_d  = clk_out_q;

            if (bus.sync_clr) begin
                cnt_d = '0;
                if (pend_q) begin
                    div_d  = pend_div_q;
                    pend_d = 1'b0;
                end
                clk_out_d = (eff_of(div_d) >= DIV_W'(2));
            end else if (bus.en) begin
                if (wrap) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        div_d  = pend_div_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                // High for the first floor(div/2) counts of the period.
                clk_out_d = (cnt_d < (eff_of(div_d) >> 1));
            end

            // Only reachable when pend_q is clear, so a same-cycle wrap/clear never consumes it.
            if (ld_acc) begin
                pend_d     = 1'b1;
                pend_div_d = bus.ld_div;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q      <= '0;
                div_q      <= DEF_DIV;
                pend_div_q <= '0;
                pend_q     <= 1'b0;
                clk_out_q  <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                div_q      <= div_d;
                pend_div_q <= pend_div_d;
                pend_q     <= pend_d;
                clk_out_q  <= clk_out_d;
            end
        end

        assign pend_vec[gi]    = pend_q;
        assign tick_vec[gi]    = bus.en & wrap;
        assign clk_out_vec[gi] = clk_out_q;
    end

`ifdef CLKDIV_TAP_EN
    logic [TAP_W-1:0] tap_q, tap_d;

    assign tap_d = tap_q + TAP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= '0;
        end else begin
            tap_q <= tap_d;
        end
    end

    assign bus.tap = tap_q;
`else
    assign bus.tap = {TAP_W{1'b0}};
`endif

endmodule

// File: tb/tb_clock_divisor_multi.sv
// Directed bench for clock_divisor_multi: default ratio, loads, divide-by-1, enable hold,
// sync clear, wrap-cycle loads, out-of-range channel, async reset and tap output.
module tb_clock_divisor_multi;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   edges;

    always #5 clk = ~clk;

    clock_divisor_multi_if #(.NUM_CH(4), .DIV_W(24), .TAP_W(4)) bus_a ();
    clock_divisor_multi_if #(.NUM_CH(3), .DIV_W(8),  .TAP_W(4)) bus_b ();

    clock_divisor_multi #(.NUM_CH(4), .DIV_W(24), .DEFAULT_DIV(4), .TAP_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    clock_divisor_multi #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(4), .TAP_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Edges since reset release; the tap counter must equal this modulo 16.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tap(input string tag);
`ifdef CLKDIV_TAP_EN
        chk(tag, 32'(bus_a.tap), 32'(edges % 16));
`else
        chk(tag, 32'(bus_a.tap), 32'd0);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Default div=4, edges 1..8 after enable: tick at cnt==3, clk_out = cnt<2.
    logic [7:0] t1_tick = 8'b0100_0100;
    logic [7:0] t1_clk  = 8'b1001_1001;
    // ch1 div=5, others div=4, edges 13..21.
    logic [3:0] t2_tick [0:8] = '{4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0000,
                                  4'b0000, 4'b1101, 4'b0000, 4'b0010};
    logic [3:0] t2_clk  [0:8] = '{4'b1111, 4'b0000, 4'b0000, 4'b1101, 4'b1111,
                                  4'b0010, 4'b0000, 4'b1101, 4'b1101};
    // ch3 new div=7 from edge 36: edges 36..43.
    logic [7:0] t5_tick = 8'b0100_0000;
    logic [7:0] t5_clk  = 8'b1000_0111;
    // After sync_clr: ch0 div1 (->2 at next wrap), ch1 div3, ch2 div1, ch3 div7; edges 45..52.
    logic [3:0] t4_tick [0:7] = '{4'b0101, 4'b0100, 4'b0111, 4'b0100,
                                  4'b0101, 4'b0110, 4'b1101, 4'b0100};
    logic [3:0] t4_clk  [0:7] = '{4'b1010, 4'b1001, 4'b1000, 4'b0011,
                                  4'b0000, 4'b0001, 4'b0010, 4'b1001};

    initial begin
        rst_n = 1'b0;
        bus_a.en = 1'b0; bus_a.sync_clr = 1'b0; bus_a.ld_valid = 1'b0;
        bus_a.ld_ch = '0; bus_a.ld_div = '0;
        bus_b.en = 1'b0; bus_b.sync_clr = 1'b0; bus_b.ld_valid = 1'b0;
        bus_b.ld_ch = 2'd2; bus_b.ld_div = '0;
        #2;
        chk("rst_tick",    32'(bus_a.tick),     32'd0);
        chk("rst_clk_out", 32'(bus_a.clk_out),  32'd0);
        chk("rst_ready",   32'(bus_a.ld_ready), 32'd1);
        chk_tap("rst_tap");
        cyc(); cyc();
        chk("rst_hold_clk_out", 32'(bus_a.clk_out), 32'd0);

        // Default ratio 4
        cyc();
        rst_n = 1'b1; bus_a.en = 1'b1;
        #1;
        chk("t1_pre_tick", 32'(bus_a.tick),    32'd0);
        chk("t1_pre_clk",  32'(bus_a.clk_out), 32'd0);
        chk("b_ready_ch2", 32'(bus_b.ld_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("t1_tick_e%0d", k + 1), 32'(bus_a.tick),    32'({4{t1_tick[k]}}));
            chk($sformatf("t1_clk_e%0d", k + 1),  32'(bus_a.clk_out), 32'({4{t1_clk[k]}}));
        end
        chk_tap("t1_tap");

        // Load ch1 div=5 mid-period
        cyc();
        bus_a.ld_valid = 1'b1; bus_a.ld_ch = 2'd1; bus_a.ld_div = 24'd5;
        #1;
        chk("t2_ready_before", 32'(bus_a.ld_ready), 32'd1);
        cyc();
        bus_a.ld_valid = 1'b0;
        #1;
        chk("t2_ready_pending", 32'(bus_a.ld_ready), 32'd0);
        cyc();
        chk("t2_old_period_tick", 32'(bus_a.tick),     32'hF);
        chk("t2_ready_still_low", 32'(bus_a.ld_ready), 32'd0);
        cyc();
        chk("t2_ready_after_wrap", 32'(bus_a.ld_ready), 32'd1);
        chk("t2_wrap_tick",        32'(bus_a.tick),     32'd0);
        chk("t2_wrap_clk",         32'(bus_a.clk_out),  32'hF);
        for (int k = 0; k < 9; k++) begin
            cyc();
            chk($sformatf("t2_tick_e%0d", k + 13), 32'(bus_a.tick),    32'(t2_tick[k]));
            chk($sformatf("t2_clk_e%0d", k + 13),  32'(bus_a.clk_out), 32'(t2_clk[k]));
        end

        // Realign all channels
        bus_a.sync_clr = 1'b1;
        cyc();
        bus_a.sync_clr = 1'b0;
        #1;
        chk("clr_tick", 32'(bus_a.tick),    32'd0);
        chk("clr_clk",  32'(bus_a.clk_out), 32'hF);
        chk_tap("clr_tap");

        // ch0 div=0, ch2 div=1, then en=0 hold
        bus_a.ld_valid = 1'b1; bus_a.ld_ch = 2'd0; bus_a.ld_div = 24'd0;
        cyc();
        bus_a.ld_ch = 2'd2; bus_a.ld_div = 24'd1;
        cyc();
        bus_a.ld_valid = 1'b0;
        cyc();
        chk("t3_e25_tick", 32'(bus_a.tick), 32'b1101);
        cyc();
        chk("t3_e26_tick", 32'(bus_a.tick),    32'b0111);
        chk("t3_e26_clk",  32'(bus_a.clk_out), 32'b1000);
        cyc();
        chk("t3_e27_tick", 32'(bus_a.tick),    32'b0101);
        chk("t3_e27_clk",  32'(bus_a.clk_out), 32'b1010);
        bus_a.en = 1'b0;
        #1;
        chk("t3_en0_tick", 32'(bus_a.tick), 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk($sformatf("t3_hold_tick_%0d", k), 32'(bus_a.tick),    32'd0);
            chk($sformatf("t3_hold_clk_%0d", k),  32'(bus_a.clk_out), 32'b1010);
        end
        chk_tap("t3_hold_tap");
        bus_a.en = 1'b1;
        #1;
        chk("t3_en1_tick", 32'(bus_a.tick), 32'b0101);
        cyc();
        chk("t3_e30_tick", 32'(bus_a.tick),    32'b0101);
        chk("t3_e30_clk",  32'(bus_a.clk_out), 32'b0010);

        // Load accepted on ch3 wrap cycle takes effect one old period later
        cyc();
        bus_a.ld_valid = 1'b1; bus_a.ld_ch = 2'd3; bus_a.ld_div = 24'd7;
        bus_b.ld_valid = 1'b1; bus_b.ld_ch = 2'd3; bus_b.ld_div = 8'd5;
        #1;
        chk("t5_wrap_tick3", 32'(bus_a.tick[3]),  32'd1);
        chk("t5_ready",      32'(bus_a.ld_ready), 32'd1);
        chk("b_oor_ready_0", 32'(bus_b.ld_ready), 32'd0);
        cyc();
        bus_a.ld_valid = 1'b0;
        #1;
        chk("t5_ready_pending", 32'(bus_a.ld_ready), 32'd0);
        chk("t5_e32_tick3",     32'(bus_a.tick[3]),  32'd0);
        chk("b_oor_ready_1",    32'(bus_b.ld_ready), 32'd0);
        cyc();
        chk("t5_e33_clk3", 32'(bus_a.clk_out[3]), 32'd1);
        cyc();
        chk("t5_e34_clk3", 32'(bus_a.clk_out[3]), 32'd0);
        chk("b_oor_ready_2", 32'(bus_b.ld_ready), 32'd0);
        cyc();
        chk("t5_e35_clk3",  32'(bus_a.clk_out[3]), 32'd0);
        chk("t5_e35_tick3", 32'(bus_a.tick[3]),    32'd1);
        bus_b.ld_valid = 1'b0; bus_b.ld_ch = 2'd2;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 0) chk("t5_ready_applied", 32'(bus_a.ld_ready), 32'd1);
            chk($sformatf("t5_tick3_e%0d", k + 36), 32'(bus_a.tick[3]),    32'(t5_tick[k]));
            chk($sformatf("t5_clk3_e%0d", k + 36),  32'(bus_a.clk_out[3]), 32'(t5_clk[k]));
        end
        chk("b_ready_ch2_end", 32'(bus_b.ld_ready), 32'd1);

        // sync_clr applies a queued load; a load in the clear cycle stays queued
        bus_a.ld_valid = 1'b1; bus_a.ld_ch = 2'd1; bus_a.ld_div = 24'd3;
        #1;
        chk("t4_ready_ch1", 32'(bus_a.ld_ready), 32'd1);
        chk("t4_tick1",     32'(bus_a.tick[1]),  32'd1);
        cyc();
        bus_a.sync_clr = 1'b1; bus_a.ld_ch = 2'd0; bus_a.ld_div = 24'd2;
        #1;
        chk("t4_ready_ch0", 32'(bus_a.ld_ready), 32'd1);
        cyc();
        bus_a.sync_clr = 1'b0; bus_a.ld_valid = 1'b0;
        #1;
        chk("t4_ch0_pending", 32'(bus_a.ld_ready), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            chk($sformatf("t4_tick_e%0d", k + 45), 32'(bus_a.tick),    32'(t4_tick[k]));
            chk($sformatf("t4_clk_e%0d", k + 45),  32'(bus_a.clk_out), 32'(t4_clk[k]));
        end
        chk_tap("t4_tap");

        // Async reset mid-period discards a queued load
        bus_a.ld_valid = 1'b1; bus_a.ld_ch = 2'd3; bus_a.ld_div = 24'd9;
        cyc();
        bus_a.ld_valid = 1'b0;
        #1;
        chk("rst2_pre_ready", 32'(bus_a.ld_ready), 32'd0);
        chk("rst2_pre_clk",   32'(bus_a.clk_out),  32'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_tick",  32'(bus_a.tick),     32'd0);
        chk("rst2_clk",   32'(bus_a.clk_out),  32'd0);
        chk("rst2_ready", 32'(bus_a.ld_ready), 32'd1);
        chk_tap("rst2_tap");
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rst2_rel_clk", 32'(bus_a.clk_out), 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("rst2_tick_e%0d", k + 1), 32'(bus_a.tick),    32'({4{t1_tick[k]}}));
            chk($sformatf("rst2_clk_e%0d", k + 1),  32'(bus_a.clk_out), 32'({4{t1_clk[k]}}));
        end
        chk_tap("rst2_end_tap");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
